// File: rtl/afe_thr_unit_type1_if.sv
// ----------------------------------------------------------------------------
// afe_thr_unit_type1_if
//   Bundles the two buses that feed the AFE threshold unit:
//   - cfg bus (APB-side): cfg_sel_i, cfg_wr_i, cfg_addr_i, cfg_wdata_i -> unit,
//     cfg_rdata_o <- unit (combinational, 0 when not reading)
//   - AFE data bus: afe_data_vld_i (asynchronous toggle-high valid) and
//     afe_data_i (sample + channel ID, stable while valid is high) -> unit
//   Modports: master drives the buses (cfg bridge / AFE mux / testbench),
//   slave is the threshold unit.
// ----------------------------------------------------------------------------
interface afe_thr_unit_type1_if #(
    parameter int W_CFG_ADDR = 10
);
    logic                  cfg_sel_i;
    logic                  cfg_wr_i;
    logic [W_CFG_ADDR-1:0] cfg_addr_i;
    logic [31:0]           cfg_wdata_i;
    logic [31:0]           cfg_rdata_o;
    logic                  afe_data_vld_i;
    logic [31:0]           afe_data_i;

    modport master (
        output cfg_sel_i, cfg_wr_i, cfg_addr_i, cfg_wdata_i,
        output afe_data_vld_i, afe_data_i,
        input  cfg_rdata_o
    );

    modport slave (
        input  cfg_sel_i, cfg_wr_i, cfg_addr_i, cfg_wdata_i,
        input  afe_data_vld_i, afe_data_i,
        output cfg_rdata_o
    );
endinterface

// File: rtl/afe_thr_unit_type1.sv
// ----------------------------------------------------------------------------
// afe_thr_unit_type1
//   Per-channel low/high window comparator with debounce and hysteresis.
//   A sample strobe (synchronised from the AFE valid toggle) evaluates the
//   addressed channel's alarm FSM; alarm entries raise 1-cycle event pulses
//   and are accumulated in a clear-on-read event buffer.
//   Ports:
//     clk_i, rstn_i  clock, asynchronous active-low reset
//     bus            cfg + AFE data buses (slave modport)
//     thr_events_o   registered 1-cycle event pulses, one per channel
//     alarm_o        level, channel is in ALARM_LO or ALARM_HI
// ----------------------------------------------------------------------------
module afe_thr_unit_type1 #(
    parameter int W_CFG_ADDR  = 10,
    parameter int W_AFE_DATA  = 16,
    parameter int NUM_CH      = 8,
    parameter int CH_ID_LSB   = 28,
    parameter int CH_ID_WIDTH = 4,
    parameter int W_CNT       = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    afe_thr_unit_type1_if.slave  bus,
    output logic [NUM_CH-1:0]    thr_events_o,
    output logic [NUM_CH-1:0]    alarm_o
);
    // Release bounds need sign extension plus one guard bit so that an
    // unsigned hysteresis added to / subtracted from a signed threshold never wraps.
    localparam int W_BND = W_AFE_DATA + 2;

    typedef enum logic [2:0] {
        ST_NORMAL, ST_PEND_LO, ST_PEND_HI, ST_ALARM_LO, ST_ALARM_HI
    } state_e;

    function automatic logic [1:0] state_code(input state_e s);
        case (s)
            ST_PEND_LO, ST_PEND_HI: return 2'd1;
            ST_ALARM_LO:            return 2'd2;
            ST_ALARM_HI:            return 2'd3;
            default:                return 2'd0;
        endcase
    endfunction

    // Configuration and per-channel state
    logic signed [W_AFE_DATA-1:0] cmp_lo [NUM_CH];
    logic signed [W_AFE_DATA-1:0] cmp_hi [NUM_CH];
    logic        [W_AFE_DATA-1:0] hyst   [NUM_CH];
    logic        [W_CNT-1:0]      deb    [NUM_CH];
    logic [NUM_CH-1:0] mask_lo, mask_hi, buf_lo, buf_hi;
    logic              single_evt;
    state_e            state_q [NUM_CH], state_d [NUM_CH];
    logic [W_CNT-1:0]  cnt_q   [NUM_CH], cnt_d   [NUM_CH];
    logic [2:0]        sync_q;

    // Bus decode
    logic [2:0] page;
    logic [4:0] ch_a;
    logic       cfg_we, cfg_re, mask_we, buf_re;
    assign page    = bus.cfg_addr_i[7:5];
    assign ch_a    = bus.cfg_addr_i[4:0];
    assign cfg_we  = bus.cfg_sel_i &  bus.cfg_wr_i;
    assign cfg_re  = bus.cfg_sel_i & ~bus.cfg_wr_i;
    assign mask_we = cfg_we && page == 3'b100 && bus.cfg_addr_i[2:0] == 3'd0;
    assign buf_re  = cfg_re && page == 3'b100 && bus.cfg_addr_i[2:0] == 3'd2;

    // Sample strobe and channel selection
    logic                          strobe;
    logic [CH_ID_WIDTH-1:0]        id;
    logic signed [W_AFE_DATA-1:0]  samp;
    assign strobe = sync_q[1] & ~sync_q[2];
    assign id     = bus.afe_data_i[CH_ID_LSB +: CH_ID_WIDTH];
    assign samp   = bus.afe_data_i[W_AFE_DATA-1:0];

    logic signed [W_AFE_DATA-1:0] sel_lo, sel_hi;
    logic        [W_AFE_DATA-1:0] sel_hyst;
    logic        [W_CNT-1:0]      sel_deb, sel_cnt;
    state_e                       sel_st;
    logic                         sel_mlo, sel_mhi;

    // NOTE: every output of a combinational block gets a default before any
    // branch; otherwise an unassigned path infers a latch.
    always_comb begin
        sel_lo = '0; sel_hi = '0; sel_hyst = '0; sel_deb = '0; sel_cnt = '0;
        sel_st = ST_NORMAL; sel_mlo = 1'b0; sel_mhi = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (id == CH_ID_WIDTH'(c)) begin
                sel_lo = cmp_lo[c]; sel_hi = cmp_hi[c]; sel_hyst = hyst[c];
                sel_deb = deb[c];   sel_cnt = cnt_q[c]; sel_st = state_q[c];
                sel_mlo = mask_lo[c]; sel_mhi = mask_hi[c];
            end
        end
    end

    // Comparators; lo wins when both windows are hit
    logic lo_hit, hi_hit;
    logic signed [W_BND-1:0] samp_x, lo_bound, hi_bound;
    assign lo_hit   = sel_mlo && (samp <= sel_lo);
    assign hi_hit   = sel_mhi && (samp >= sel_hi) && !lo_hit;
    assign samp_x   = W_BND'(samp);
    assign lo_bound = W_BND'(sel_lo) + W_BND'($signed({1'b0, sel_hyst}));
    assign hi_bound = W_BND'(sel_hi) - W_BND'($signed({1'b0, sel_hyst}));

    // FSM next state for the strobed channel
    state_e           norm_st, nx_st;
    logic [W_CNT-1:0] norm_cnt, nx_cnt;
    logic             norm_lo, norm_hi, ev_lo, ev_hi;
    logic [W_CNT:0]   cnt_inc;
    assign cnt_inc = {1'b0, sel_cnt} + 1'b1;

    always_comb begin
        // What a NORMAL channel does with this sample; reused on every exit path
        norm_st = ST_NORMAL; norm_cnt = '0; norm_lo = 1'b0; norm_hi = 1'b0;
        if (lo_hit) begin
            if (sel_deb <= W_CNT'(1)) begin norm_st = ST_ALARM_LO; norm_lo = 1'b1; end
            else begin norm_st = ST_PEND_LO; norm_cnt = W_CNT'(1); end
        end else if (hi_hit) begin
            if (sel_deb <= W_CNT'(1)) begin norm_st = ST_ALARM_HI; norm_hi = 1'b1; end
            else begin norm_st = ST_PEND_HI; norm_cnt = W_CNT'(1); end
        end

        nx_st = norm_st; nx_cnt = norm_cnt; ev_lo = norm_lo; ev_hi = norm_hi;
        case (sel_st)
            ST_PEND_LO: if (lo_hit) begin
                ev_hi = 1'b0;
                if (cnt_inc >= {1'b0, sel_deb}) begin
                    nx_st = ST_ALARM_LO; nx_cnt = '0; ev_lo = 1'b1;
                end else begin
                    nx_st = ST_PEND_LO; nx_cnt = cnt_inc[W_CNT-1:0]; ev_lo = 1'b0;
                end
            end
            ST_PEND_HI: if (hi_hit) begin
                ev_lo = 1'b0;
                if (cnt_inc >= {1'b0, sel_deb}) begin
                    nx_st = ST_ALARM_HI; nx_cnt = '0; ev_hi = 1'b1;
                end else begin
                    nx_st = ST_PEND_HI; nx_cnt = cnt_inc[W_CNT-1:0]; ev_hi = 1'b0;
                end
            end
            ST_ALARM_LO: if (!(samp_x > lo_bound)) begin
                nx_st = ST_ALARM_LO; nx_cnt = sel_cnt; ev_lo = 1'b0; ev_hi = 1'b0;
            end
            ST_ALARM_HI: if (!(samp_x < hi_bound)) begin
                nx_st = ST_ALARM_HI; nx_cnt = sel_cnt; ev_lo = 1'b0; ev_hi = 1'b0;
            end
            default: ;
        endcase
    end

    // Per-channel next state; a mask write drops channels whose active side is masked
    logic [NUM_CH-1:0] set_lo, set_hi, thr_events_n;
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            set_lo[c]  = 1'b0;
            set_hi[c]  = 1'b0;
            if (strobe && id == CH_ID_WIDTH'(c)) begin
                state_d[c] = nx_st; cnt_d[c] = nx_cnt;
                set_lo[c]  = ev_lo; set_hi[c] = ev_hi;
            end
            if (mask_we &&
                ((!bus.cfg_wdata_i[c] &&
                  (state_d[c] == ST_PEND_LO || state_d[c] == ST_ALARM_LO)) ||
                 (!bus.cfg_wdata_i[16+c] &&
                  (state_d[c] == ST_PEND_HI || state_d[c] == ST_ALARM_HI)))) begin
                state_d[c] = ST_NORMAL; cnt_d[c] = '0;
            end
        end
    end

    assign thr_events_n = single_evt ? ((set_lo & ~buf_lo) | (set_hi & ~buf_hi))
                                     : (set_lo | set_hi);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_NORMAL;
                cnt_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    // NOTE: the threshold tables are small flop arrays, not RAM, and they are
    // reset so a freshly reset channel can never alarm on stale thresholds.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmp_lo[c] <= '0; cmp_hi[c] <= '0; hyst[c] <= '0; deb[c] <= '0;
            end
            mask_lo <= '0; mask_hi <= '0; buf_lo <= '0; buf_hi <= '0;
            single_evt <= 1'b0; sync_q <= '0; thr_events_o <= '0;
        end else begin
            sync_q       <= {sync_q[1:0], bus.afe_data_vld_i};
            thr_events_o <= thr_events_n;
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_we && ch_a == 5'(c)) begin
                    case (page)
                        3'b000: cmp_lo[c] <= bus.cfg_wdata_i[W_AFE_DATA-1:0];
                        3'b001: cmp_hi[c] <= bus.cfg_wdata_i[W_AFE_DATA-1:0];
                        3'b010: hyst[c]   <= bus.cfg_wdata_i[W_AFE_DATA-1:0];
                        3'b011: deb[c]    <= bus.cfg_wdata_i[W_CNT-1:0];
                        default: ;
                    endcase
                end
            end
            if (mask_we) begin
                mask_lo <= bus.cfg_wdata_i[NUM_CH-1:0];
                mask_hi <= bus.cfg_wdata_i[16 +: NUM_CH];
            end
            if (cfg_we && page == 3'b100 && bus.cfg_addr_i[2:0] == 3'd4)
                single_evt <= bus.cfg_wdata_i[0];
            // A clearing read reloads with this cycle's events so none are lost
            if (buf_re) begin
                buf_lo <= set_lo;          buf_hi <= set_hi;
            end else begin
                buf_lo <= buf_lo | set_lo; buf_hi <= buf_hi | set_hi;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            alarm_o[c] = state_q[c] == ST_ALARM_LO || state_q[c] == ST_ALARM_HI;
    end

    // Read mux
    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        if (cfg_re) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_a == 5'(c)) begin
                    case (page)
                        3'b000: rdata = 32'(cmp_lo[c]);
                        3'b001: rdata = 32'(cmp_hi[c]);
                        3'b010: rdata = 32'(hyst[c]);
                        3'b011: rdata = 32'(deb[c]);
                        default: ;
                    endcase
                end
            end
            if (page == 3'b100) begin
                case (bus.cfg_addr_i[2:0])
                    3'd0: begin rdata[NUM_CH-1:0] = mask_lo; rdata[16 +: NUM_CH] = mask_hi; end
                    3'd2: begin rdata[NUM_CH-1:0] = buf_lo;  rdata[16 +: NUM_CH] = buf_hi;  end
                    3'd4: rdata[0] = single_evt;
                    3'd5: for (int c = 0; c < NUM_CH; c++) rdata[2*c +: 2] = state_code(state_q[c]);
                    default: ;
                endcase
            end
        end
    end
    assign bus.cfg_rdata_o = rdata;

    // Bus bits that carry no information for this configuration
    logic unused_bits;
    assign unused_bits = ^{bus.cfg_wdata_i, bus.afe_data_i, bus.cfg_addr_i[W_CFG_ADDR-1:0]};
endmodule

// File: tb/tb_afe_thr_unit_type1.sv
// ----------------------------------------------------------------------------
// tb_afe_thr_unit_type1
//   Directed bench for afe_thr_unit_type1 (NUM_CH = 8): a vector table for the
//   basic lo / debounce / hysteresis flows, followed by hand-written sequences
//   for single-event mode, mask changes, out-of-range IDs, bound overflow and
//   reset during debounce.
// ----------------------------------------------------------------------------
module tb_afe_thr_unit_type1;
    localparam int NUM_CH = 8;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic [NUM_CH-1:0] thr_events_o, alarm_o;

    afe_thr_unit_type1_if #(.W_CFG_ADDR(10)) bus ();

    afe_thr_unit_type1 dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .bus          (bus),
        .thr_events_o (thr_events_o),
        .alarm_o      (alarm_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ev, tail;
    logic [31:0] d;

    typedef struct {
        int         ch;
        int         s;
        logic [7:0] evt;
        logic [7:0] alarm;
        logic [1:0] st;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] a(input int page, input int ch);
        return {2'b00, page[2:0], ch[4:0]};
    endfunction

    task automatic wr(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b1; bus.cfg_wr_i = 1'b1;
        bus.cfg_addr_i = addr; bus.cfg_wdata_i = data;
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b0; bus.cfg_wr_i = 1'b0;
    endtask

    task automatic rd(input logic [9:0] addr, output logic [31:0] data);
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b1; bus.cfg_wr_i = 1'b0; bus.cfg_addr_i = addr;
        #1 data = bus.cfg_rdata_o;
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b0;
    endtask

    task automatic rd_state(input int ch, output logic [1:0] st);
        logic [31:0] r;
        rd(a(4, 5), r);
        st = r[2*ch +: 2];
    endtask

    // Raise valid, capture the event pulse after the 3rd edge and the line
    // one edge later, then let the synchroniser drain.
    task automatic send(input int ch, input int s);
        @(negedge clk_i);
        bus.afe_data_i = {ch[3:0], 12'h000, s[15:0]};
        bus.afe_data_vld_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 ev = thr_events_o;
        @(negedge clk_i);
        bus.afe_data_vld_i = 1'b0;
        @(posedge clk_i);
        #1 tail = thr_events_o;
        repeat (3) @(posedge clk_i);
    endtask

    task automatic send_chk(input string name, input int ch, input int s,
                            input logic [7:0] exp_ev, input logic exp_alarm);
        send(ch, s);
        check({name, "_evt"}, 32'(ev), 32'(exp_ev));
        check({name, "_alarm"}, 32'(alarm_o[ch]), 32'(exp_alarm));
    endtask

    initial begin
        logic [1:0] st;

        vecs[0]  = '{2, -150, 8'h04, 8'h04, 2'd2};
        vecs[1]  = '{0, 1200, 8'h00, 8'h04, 2'd1};
        vecs[2]  = '{0, 1200, 8'h00, 8'h04, 2'd1};
        vecs[3]  = '{0,  900, 8'h00, 8'h04, 2'd0};
        vecs[4]  = '{0, 1200, 8'h00, 8'h04, 2'd1};
        vecs[5]  = '{0, 1200, 8'h00, 8'h04, 2'd1};
        vecs[6]  = '{0, 1200, 8'h01, 8'h05, 2'd3};
        vecs[7]  = '{1,  600, 8'h02, 8'h07, 2'd3};
        vecs[8]  = '{1,  480, 8'h00, 8'h07, 2'd3};
        vecs[9]  = '{1,  449, 8'h00, 8'h05, 2'd0};
        vecs[10] = '{1,  520, 8'h02, 8'h07, 2'd3};

        bus.cfg_sel_i = 1'b0; bus.cfg_wr_i = 1'b0; bus.cfg_addr_i = '0;
        bus.cfg_wdata_i = '0; bus.afe_data_vld_i = 1'b0; bus.afe_data_i = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1 check("rst_events", 32'(thr_events_o), 32'h0);
        check("rst_alarm", 32'(alarm_o), 32'h0);
        @(negedge clk_i) rstn_i = 1'b1;
        rd(a(4, 5), d); check("rst_state", d, 32'h0);
        rd(a(4, 0), d); check("rst_mask", d, 32'h0);

        // Configuration for the table
        wr(a(0, 2), -100);  wr(a(3, 2), 1);
        wr(a(1, 0), 1000);  wr(a(3, 0), 3);
        wr(a(1, 1), 500);   wr(a(2, 1), 50);  wr(a(3, 1), 1);
        wr(a(4, 0), 32'h0003_0004);
        rd(a(2, 1), d); check("hyst_readback", d, 32'd50);
        rd(a(0, 2), d); check("cmp_lo_readback", d, 32'hFFFF_FF9C);
        wr(a(0, 9), 123);
        rd(a(0, 9), d); check("ch_out_of_range", d, 32'h0);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].ch, vecs[i].s);
            check($sformatf("vec%0d_evt", i), 32'(ev), 32'(vecs[i].evt));
            check($sformatf("vec%0d_pulse_end", i), 32'(tail), 32'h0);
            check($sformatf("vec%0d_alarm", i), 32'(alarm_o), 32'(vecs[i].alarm));
            rd_state(vecs[i].ch, st);
            check($sformatf("vec%0d_state", i), 32'(st), 32'(vecs[i].st));
        end
        rd(a(4, 2), d); check("buf_after_table", d, 32'h0003_0004);
        rd(a(4, 2), d); check("buf_cleared", d, 32'h0);

        // Single-event mode on ch3
        wr(a(4, 4), 1);
        wr(a(3, 3), 1);
        wr(a(4, 0), 32'h0003_000C);
        send_chk("se_first",   3, -10, 8'h08, 1'b1);
        send_chk("se_rel1",    3,  10, 8'h00, 1'b0);
        send_chk("se_second",  3, -10, 8'h00, 1'b1);
        send_chk("se_rel2",    3,  10, 8'h00, 1'b0);
        rd(a(4, 2), d); check("se_buf_read", d, 32'h0000_0008);
        rd(a(4, 2), d); check("se_buf_clr", d, 32'h0);
        send_chk("se_rearmed", 3, -10, 8'h08, 1'b1);
        send_chk("se_rel3",    3,  10, 8'h00, 1'b0);
        rd(a(4, 2), d); check("se_buf_read2", d, 32'h0000_0008);

        // Buffer read in the same cycle as a new event
        @(negedge clk_i);
        bus.afe_data_i = {4'd3, 12'h000, 16'hFFF6};
        bus.afe_data_vld_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b1; bus.cfg_wr_i = 1'b0; bus.cfg_addr_i = a(4, 2);
        #1 check("coinc_read_old", bus.cfg_rdata_o, 32'h0);
        @(posedge clk_i);
        #1 check("coinc_evt", 32'(thr_events_o), 32'h08);
        @(negedge clk_i);
        bus.cfg_sel_i = 1'b0; bus.afe_data_vld_i = 1'b0;
        repeat (4) @(posedge clk_i);
        rd(a(4, 2), d); check("coinc_evt_kept", d, 32'h0000_0008);
        wr(a(4, 4), 0);

        // Masking the active side drops the channel to NORMAL
        wr(a(4, 0), 32'h0003_0008);
        #1 check("mask_alarm2", 32'(alarm_o), 32'h0B);
        rd_state(2, st); check("mask_state2", 32'(st), 32'd0);

        // Channel ID beyond NUM_CH is ignored
        send(12, -30000);
        check("id12_evt", 32'(ev), 32'h0);
        check("id12_alarm", 32'(alarm_o), 32'h0B);
        rd(a(4, 5), d); check("id12_state", d, 32'h0000_008F);

        // Release bounds at the numeric extremes
        wr(a(1, 4), 32767); wr(a(2, 4), 32767); wr(a(3, 4), 1);
        wr(a(4, 0), 32'h0013_0008);
        send_chk("ovf_hi_set",  4, 32767, 8'h10, 1'b1);
        send_chk("ovf_hi_hold", 4,     0, 8'h00, 1'b1);
        send_chk("ovf_hi_rel",  4,    -1, 8'h00, 1'b0);
        wr(a(0, 5), 32767); wr(a(2, 5), 32767); wr(a(3, 5), 1);
        wr(a(4, 0), 32'h0013_0028);
        send_chk("ovf_lo_set",  5,     0, 8'h20, 1'b1);
        send_chk("ovf_lo_hold", 5,   100, 8'h00, 1'b1);

        // Reset while a channel is mid-debounce
        wr(a(1, 6), 100); wr(a(3, 6), 3);
        wr(a(4, 0), 32'h0053_0028);
        send(6, 200); send(6, 200);
        rd_state(6, st); check("pre_rst_pend", 32'(st), 32'd1);
        @(negedge clk_i) rstn_i = 1'b0;
        #1 check("midrst_alarm", 32'(alarm_o), 32'h0);
        check("midrst_events", 32'(thr_events_o), 32'h0);
        @(negedge clk_i) rstn_i = 1'b1;
        rd(a(4, 5), d); check("post_rst_state", d, 32'h0);
        rd(a(4, 0), d); check("post_rst_mask", d, 32'h0);
        wr(a(1, 6), 100); wr(a(3, 6), 3);
        wr(a(4, 0), 32'h0040_0000);
        send_chk("fresh1", 6, 200, 8'h00, 1'b0);
        send_chk("fresh2", 6, 200, 8'h00, 1'b0);
        send_chk("fresh3", 6, 200, 8'h40, 1'b1);
        rd_state(6, st); check("fresh_state", 32'(st), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
